holl_fpdiv_seq: RTL

HOLL_FPDIV_SEQ -- requirements
Module: holl_fpdiv_seq

---
 rtl/holl_fpdiv_pkg.sv | 46 ++++
 rtl/holl_fpdiv_core.sv | 82 ++++++++
 rtl/holl_fpdiv_seq.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/holl_fpdiv_pkg.sv
// Shared types and constants for the sequential floating-point divider.
// Holds FSM states, register addresses, STATUS bit positions and IEEE-style field helpers.
package holl_fpdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_DIV  = 2'd2,
    ST_NORM = 2'd3
  } state_e;

  // Operand class resolved in PREP and consumed in NORM
  typedef enum logic [2:0] {
    SP_NONE = 3'd0,
    SP_ZERO = 3'd1,
    SP_INF  = 3'd2,
    SP_DBZ  = 3'd3,
    SP_NAN  = 3'd4
  } special_e;

  localparam logic [4:0] ADDR_OPA    = 5'd0;
  localparam logic [4:0] ADDR_OPB    = 5'd1;
  localparam logic [4:0] ADDR_CTRL   = 5'd2;
  localparam logic [4:0] ADDR_STATUS = 5'd3;
  localparam logic [4:0] ADDR_RESULT = 5'd4;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_DBZ  = 2;
  localparam int STAT_OVF  = 3;
  localparam int STAT_UNF  = 4;
  localparam int STAT_INV  = 5;

  function automatic logic [31:0] fp_bias(input int exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] fp_inf(input int exp_w, input int frac_w);
    return ((32'd1 << exp_w) - 32'd1) << frac_w;
  endfunction

  function automatic logic [31:0] fp_qnan(input int exp_w, input int frac_w);
    return fp_inf(exp_w, frac_w) | (32'd1 << (frac_w - 1));
  endfunction

endpackage

// File: rtl/holl_fpdiv_core.sv
// Iterative restoring mantissa divider: one quotient bit per cycle, FRAC_W+3 bits total.
// quotient = floor(dividend * 2^(FRAC_W+2) / divisor); remainder is nonzero iff the division was inexact.
module holl_fpdiv_core
  #(parameter int FRAC_W = 23)
  (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [FRAC_W:0]   dividend,
    input  logic [FRAC_W:0]   divisor,
    output logic [FRAC_W+2:0] quotient,
    output logic [FRAC_W+1:0] remainder,
    output logic              last,
    output logic              done
  );

  localparam int QW = FRAC_W + 3;
  localparam int MW = FRAC_W + 1;
  localparam int RW = FRAC_W + 2;
  localparam int CW = $clog2(QW);

  logic [RW-1:0] rem_q, rem_d;
  logic [MW-1:0] dvs_q, dvs_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ge;
  logic [MW-1:0] diff;

  always_comb begin
    ge     = rem_q >= {1'b0, dvs_q};
    diff   = ge ? MW'(rem_q - {1'b0, dvs_q}) : rem_q[MW-1:0];
    last   = busy_q && (cnt_q == CW'(QW - 1));
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = done_q;
    if (start) begin
      rem_d  = {1'b0, dividend};
      dvs_d  = divisor;
      quo_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
      done_d = 1'b0;
    end else if (busy_q) begin
      // The partial remainder stays below the divisor, so the shift never loses a bit
      rem_d = {diff, 1'b0};
      quo_d = {quo_q[QW-2:0], ge};
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;

endmodule

// File: rtl/holl_fpdiv_seq.sv
// Register-mapped sequential FP divider with fixed FRAC_W+5 cycle latency, flush-to-zero.
// Define FPDIV_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module holl_fpdiv_seq
  import holl_fpdiv_pkg::*;
  #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
  )
  (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data
  );

  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int EW = EXP_W + 2;
  localparam int QW = FRAC_W + 3;
  localparam int RW = FRAC_W + 2;

  localparam logic signed [EW-1:0] BIAS  = $signed(EW'(fp_bias(EXP_W)));
  localparam logic signed [EW-1:0] EMAX  = $signed(EW'((1 << EXP_W) - 1));
  localparam logic signed [EW-1:0] EZERO = '0;
  localparam logic signed [EW-1:0] EONE  = $signed(EW'(1));
  localparam logic [W-1:0]         INF_W = W'(fp_inf(EXP_W, FRAC_W));
  localparam logic [W-1:0]         NAN_W = W'(fp_qnan(EXP_W, FRAC_W));

  state_e   state_q, state_d;
  special_e spec_q, spec_d;
  logic [W-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [W-1:0] wa_q, wa_d, wb_q, wb_d;
  logic [W-1:0] res_q, res_d;
  logic done_q, done_d, dbz_q, dbz_d, ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;
  logic sign_q, sign_d;
  logic signed [EW-1:0] exp_q, exp_d;

  logic wr_en, rd_en, idle, start_req;
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [QW-1:0] core_quo;
  logic [RW-1:0] core_rem;
  logic core_last, core_done;

  assign wr_en     = cs & write;
  assign rd_en     = cs & read;
  assign idle      = (state_q == ST_IDLE);
  assign start_req = wr_en && (addr == ADDR_CTRL) && wr_data[0];

  assign ea     = wa_q[W-2 -: EXP_W];
  assign eb     = wb_q[W-2 -: EXP_W];
  assign fa     = wa_q[FRAC_W-1:0];
  assign fb     = wb_q[FRAC_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);

  // Subnormals enter the divider with a zero hidden bit; their result is overridden anyway
  holl_fpdiv_core #(.FRAC_W(FRAC_W)) u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (state_q == ST_PREP),
    .dividend  ({~a_zero, fa}),
    .divisor   ({~b_zero, fb}),
    .quotient  (core_quo),
    .remainder (core_rem),
    .last      (core_last),
    .done      (core_done)
  );

  logic q_msb;
  logic [FRAC_W-1:0] frac_t, frac_f;
  logic signed [EW-1:0] e_n, e_f;

  assign q_msb  = core_quo[QW-1];
  assign frac_t = q_msb ? core_quo[QW-2:2] : core_quo[QW-3:1];
  assign e_n    = exp_q - (q_msb ? EZERO : EONE);

`ifdef FPDIV_RNE_EN
  logic guard, round_b, sticky, inc;
  logic [FRAC_W:0] frac_sum;

  always_comb begin
    guard    = q_msb ? core_quo[1] : core_quo[0];
    round_b  = q_msb ? core_quo[0] : 1'b0;
    sticky   = |core_rem;
    inc      = guard & (round_b | sticky | frac_t[0]);
    frac_sum = {1'b0, frac_t} + {{FRAC_W{1'b0}}, inc};
    // A carry out of the fraction means the mantissa rolled over to 2.0
    frac_f   = frac_sum[FRAC_W-1:0];
    e_f      = frac_sum[FRAC_W] ? e_n + EONE : e_n;
  end
`else
  logic unused_grs;
  assign unused_grs = ^{core_quo[0], core_rem};
  assign frac_f     = frac_t;
  assign e_f        = e_n;
`endif

  logic [W-1:0] norm_res;
  logic norm_dbz, norm_ovf, norm_unf, norm_inv;

  always_comb begin
    norm_res = '0;
    norm_dbz = 1'b0;
    norm_ovf = 1'b0;
    norm_unf = 1'b0;
    norm_inv = 1'b0;
    case (spec_q)
      SP_NAN: begin
        norm_res = NAN_W;
        norm_inv = 1'b1;
      end
      SP_INF:  norm_res = INF_W | {sign_q, {(W-1){1'b0}}};
      SP_DBZ: begin
        norm_res = INF_W | {sign_q, {(W-1){1'b0}}};
        norm_dbz = 1'b1;
      end
      SP_ZERO: norm_res = {sign_q, {(W-1){1'b0}}};
      default: begin
        if (e_f >= EMAX) begin
          norm_res = INF_W | {sign_q, {(W-1){1'b0}}};
          norm_ovf = 1'b1;
        end else if (e_f <= EZERO) begin
          norm_res = {sign_q, {(W-1){1'b0}}};
          norm_unf = 1'b1;
        end else begin
          norm_res = {sign_q, e_f[EXP_W-1:0], frac_f};
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    spec_d  = spec_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    wa_d    = wa_q;
    wb_d    = wb_q;
    res_d   = res_q;
    done_d  = done_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    inv_d   = inv_q;
    sign_d  = sign_q;
    exp_d   = exp_q;

    if (wr_en && idle) begin
      if (addr == ADDR_OPA) opa_d = wr_data[W-1:0];
      if (addr == ADDR_OPB) opb_d = wr_data[W-1:0];
    end
    if (rd_en && (addr == ADDR_RESULT)) done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d = ST_PREP;
          wa_d    = opa_q;
          wb_d    = opb_q;
          done_d  = 1'b0;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          inv_d   = 1'b0;
        end
      end
      ST_PREP: begin
        state_d = ST_DIV;
        sign_d  = wa_q[W-1] ^ wb_q[W-1];
        exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) spec_d = SP_NAN;
        else if (a_inf)                                            spec_d = SP_INF;
        else if (b_zero)                                           spec_d = SP_DBZ;
        else if (b_inf || a_zero)                                  spec_d = SP_ZERO;
        else                                                       spec_d = SP_NONE;
      end
      ST_DIV: begin
        if (core_last) state_d = ST_NORM;
      end
      ST_NORM: begin
        state_d = ST_IDLE;
        if (core_done) begin
          res_d  = norm_res;
          done_d = 1'b1;
          dbz_d  = norm_dbz;
          ovf_d  = norm_ovf;
          unf_d  = norm_unf;
          inv_d  = norm_inv;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      spec_q  <= SP_NONE;
      opa_q   <= '0;
      opb_q   <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inv_q   <= 1'b0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      spec_q  <= spec_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
      res_q   <= res_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      inv_q   <= inv_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_OPA:    rd_data = 32'(opa_q);
      ADDR_OPB:    rd_data = 32'(opb_q);
      ADDR_RESULT: rd_data = 32'(res_q);
      ADDR_STATUS: begin
        rd_data[STAT_BUSY] = ~idle;
        rd_data[STAT_DONE] = done_q;
        rd_data[STAT_DBZ]  = dbz_q;
        rd_data[STAT_OVF]  = ovf_q;
        rd_data[STAT_UNF]  = unf_q;
        rd_data[STAT_INV]  = inv_q;
      end
      default: rd_data = '0;
    endcase
  end

endmodule
